text_scan_arbiter: RTL and testbench

TEXT_SCAN_ARBITER -- requirements
Module: text_scan_arbiter

---
 rtl/text_scan_arbiter_pkg.sv | 28 ++
 rtl/scan_position_counter.sv | 38 +++
 rtl/text_scan_arbiter.sv | 176 +++++++++++++++++
 tb/tb_text_scan_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_scan_arbiter_pkg.sv
// Shared display constants, FSM state encoding and index helpers for the
// text scan arbiter and its position counter.
package text_scan_arbiter_pkg;

  localparam int CHARS_VERT = 4;
  localparam int CHARS_HORZ = 8;
  localparam int ASCII_SIZE = 8;

  localparam int NUM_CHARS = CHARS_VERT * CHARS_HORZ;
  localparam int ROW_W     = $clog2(CHARS_VERT);
  localparam int COL_W     = $clog2(CHARS_HORZ);
  localparam int IDX_W     = $clog2(NUM_CHARS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_ISSUE,
    ST_SCAN_DATA,
    ST_CPU_ISSUE,
    ST_CPU_DATA
  } arb_state_t;

  // Flat display RAM index of a (row, col) position.
  function automatic logic [IDX_W-1:0] flat_index(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(CHARS_HORZ) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/scan_position_counter.sv
// Row/column walker over the character grid in raster order, with a flag
// marking the final cell of the frame.
module scan_position_counter
  import text_scan_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CHARS_VERT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHARS_HORZ - 1);

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  // Column steps first; the row steps on column wrap, and the last cell wraps to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_scan_arbiter.sv
// Arbitrates a single-port display RAM between CPU reads/writes and the
// character scanout engine.
//
//   state         | meaning
//   --------------+----------------------------------------------------
//   ST_IDLE       | pick scan fetch or CPU access (scan_start blocks a grant)
//   ST_SCAN_ISSUE | mem_en for the character at the current scan position
//   ST_SCAN_DATA  | RAM data returns; load char_* unless the fetch was cancelled
//   ST_CPU_ISSUE  | mem_en/mem_we for the CPU (suppressed when out of range)
//   ST_CPU_DATA   | cpu_ack; read data presented and captured
module text_scan_arbiter
  import text_scan_arbiter_pkg::*;
#(
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  scan_start,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [ASCII_SIZE-1:0] char_data,
  output logic [ROW_W-1:0]      char_row,
  output logic [COL_W-1:0]      char_col,
  output logic                  frame_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [IDX_W-1:0]      mem_addr,
  output logic [ASCII_SIZE-1:0] mem_wdata,
  input  logic [ASCII_SIZE-1:0] mem_rdata
);

  localparam int               WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  arb_state_t            state;
  logic                  scan_active;
  logic                  discard;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  cpu_rd_q;
  logic                  cpu_oor_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rdata_live;

  logic [ROW_W-1:0]      pos_row;
  logic [COL_W-1:0]      pos_col;
  logic                  pos_last;

  logic [29:0]           cpu_idx;
  logic                  cpu_in_range;
  logic                  scan_elig;
  logic                  cpu_win;
  logic                  xfer;

  // Byte-lane bits of the address and upper write data are not stored.
  logic                  unused_bits;
  assign unused_bits = ^{cpu_addr[1:0], cpu_wdata[31:ASCII_SIZE]};

  assign cpu_idx      = cpu_addr[31:2];
  assign cpu_in_range = cpu_idx < 30'(NUM_CHARS);
  assign scan_elig    = scan_active && !char_valid;
  assign cpu_win      = cpu_req && (!scan_elig || (wait_cnt >= WAIT_MAX));
  assign xfer         = char_valid && char_ready;

  // Read data rides straight from the RAM during the ack cycle so it is valid
  // with cpu_ack; the captured copy holds it until the next read ack.
  assign rdata_live = cpu_oor_q ? 32'h0 : {{(32 - ASCII_SIZE){1'b0}}, mem_rdata};
  assign cpu_rdata  = (cpu_ack && cpu_rd_q) ? rdata_live : rdata_q;

  scan_position_counter u_pos (
    .clk     (clk),
    .reset   (reset),
    .clear   (scan_start),
    .advance (xfer && !scan_start),
    .row     (pos_row),
    .col     (pos_col),
    .last    (pos_last)
  );

  // Arbitration FSM plus scan bookkeeping; all outputs registered except cpu_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      scan_active <= 1'b0;
      discard     <= 1'b0;
      wait_cnt    <= '0;
      cpu_rd_q    <= 1'b0;
      cpu_oor_q   <= 1'b0;
      rdata_q     <= '0;
      cpu_ack     <= 1'b0;
      char_valid  <= 1'b0;
      char_data   <= '0;
      char_row    <= '0;
      char_col    <= '0;
      frame_done  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      frame_done <= 1'b0;

      // A restart wins over a same-cycle transfer and never raises frame_done.
      if (scan_start) begin
        scan_active <= 1'b1;
        char_valid  <= 1'b0;
      end else if (xfer) begin
        char_valid <= 1'b0;
        if (pos_last) begin
          frame_done  <= 1'b1;
          scan_active <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (!scan_start && cpu_win) begin
            state     <= ST_CPU_ISSUE;
            wait_cnt  <= '0;
            mem_en    <= cpu_in_range;
            mem_we    <= cpu_in_range && cpu_we;
            mem_addr  <= cpu_idx[IDX_W-1:0];
            mem_wdata <= cpu_wdata[ASCII_SIZE-1:0];
            cpu_rd_q  <= !cpu_we;
            cpu_oor_q <= !cpu_in_range;
          end else begin
            if (cpu_req && (wait_cnt < WAIT_MAX)) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
            if (!scan_start && scan_elig) begin
              state    <= ST_SCAN_ISSUE;
              mem_en   <= 1'b1;
              mem_addr <= flat_index(pos_row, pos_col);
            end
          end
        end
        ST_SCAN_ISSUE: begin
          state <= ST_SCAN_DATA;
          if (scan_start) begin
            discard <= 1'b1;
          end
        end
        ST_SCAN_DATA: begin
          state   <= ST_IDLE;
          discard <= 1'b0;
          if (!discard && !scan_start) begin
            char_valid <= 1'b1;
            char_data  <= mem_rdata;
            char_row   <= pos_row;
            char_col   <= pos_col;
          end
        end
        ST_CPU_ISSUE: begin
          state   <= ST_CPU_DATA;
          cpu_ack <= 1'b1;
        end
        ST_CPU_DATA: begin
          state <= ST_IDLE;
          if (cpu_rd_q) begin
            rdata_q <= rdata_live;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_scan_arbiter.sv
// Directed bench for text_scan_arbiter: CPU vector table plus hand-written
// frame, starvation, backpressure/restart and reset sequences.
module tb_text_scan_arbiter;
  import text_scan_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  cpu_req = 1'b0;
  logic                  cpu_we = 1'b0;
  logic [31:0]           cpu_addr = '0;
  logic [31:0]           cpu_wdata = '0;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ack;
  logic                  scan_start = 1'b0;
  logic                  char_valid;
  logic                  char_ready = 1'b0;
  logic [ASCII_SIZE-1:0] char_data;
  logic [ROW_W-1:0]      char_row;
  logic [COL_W-1:0]      char_col;
  logic                  frame_done;
  logic                  mem_en;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [ASCII_SIZE-1:0] mem_wdata;
  logic [ASCII_SIZE-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  text_scan_arbiter #(.CPU_MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .scan_start (scan_start),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_row   (char_row),
    .char_col   (char_col),
    .frame_done (frame_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Display RAM model: synchronous read, preloaded with its own index.
  logic [ASCII_SIZE-1:0] ram [NUM_CHARS];
  logic                  ram_load = 1'b1;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < NUM_CHARS; i++) ram[i] <= ASCII_SIZE'(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic [31:0] idx;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic cpu_txn(input string tag, input vec_t v);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    @(negedge clk);
    check({tag, " mem_en"}, 32'(mem_en), 32'(v.en));
    check({tag, " mem_we"}, 32'(mem_we), 32'(v.en && v.we));
    if (v.en) check({tag, " mem_addr"}, 32'(mem_addr), v.idx);
    if (v.en && v.we) check({tag, " mem_wdata"}, 32'(mem_wdata), {24'h0, v.wdata[7:0]});
    check({tag, " ack early"}, 32'(cpu_ack), 32'd0);
    @(negedge clk);
    check({tag, " ack"}, 32'(cpu_ack), 32'd1);
    check({tag, " rdata"}, cpu_rdata, v.rdata);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (char_valid) got = 1;
      else @(negedge clk);
    end
    check({tag, " char_valid seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int idx, cyc, last_cyc, fd_cyc, fd_cnt, lat;
    bit quiet, stable, got;
    logic [ASCII_SIZE-1:0] d0;
    logic [ROW_W-1:0]      r0;
    logic [COL_W-1:0]      c0;

    vecs[0]  = '{1'b1, 32'h0000_0008, 32'h0000_0041,  1'b1, 32'd2,  32'h00};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,          1'b1, 32'd2,  32'h41};
    vecs[2]  = '{1'b1, 32'h0000_007C, 32'h0000_01FF,  1'b1, 32'd31, 32'h41};
    vecs[3]  = '{1'b0, 32'h0000_007C, 32'h0,          1'b1, 32'd31, 32'hFF};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,          1'b1, 32'd5,  32'h05};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0000_005A,  1'b1, 32'd0,  32'h05};
    vecs[6]  = '{1'b1, 32'h0000_0080, 32'h0000_0055,  1'b0, 32'd0,  32'h05};
    vecs[7]  = '{1'b0, 32'h0000_0080, 32'h0,          1'b0, 32'd0,  32'h00};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, 32'd0,  32'h5A};
    vecs[9]  = '{1'b1, 32'h0000_0005, 32'h0000_003A,  1'b1, 32'd1,  32'h5A};
    vecs[10] = '{1'b0, 32'h0000_0004, 32'h0,          1'b1, 32'd1,  32'h3A};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          1'b0, 32'd0,  32'h00};

    // Asynchronous reset, observed before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset cpu_ack",    32'(cpu_ack),    32'd0);
    check("reset cpu_rdata",  cpu_rdata,       32'd0);
    check("reset char_valid", 32'(char_valid), 32'd0);
    check("reset mem_en",     32'(mem_en),     32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    ram_load = 1'b0;

    // Full frame with char_ready tied high.
    char_ready = 1'b1;
    pulse_start();
    idx = 0; cyc = 0; last_cyc = -1; fd_cyc = -1; fd_cnt = 0; quiet = 1;
    while (cyc < 300 && !(idx >= NUM_CHARS && cyc > last_cyc + 6)) begin
      if (char_valid) begin
        if (idx < NUM_CHARS) begin
          check($sformatf("frame row %0d", idx), 32'(char_row),  32'(idx / CHARS_HORZ));
          check($sformatf("frame col %0d", idx), 32'(char_col),  32'(idx % CHARS_HORZ));
          check($sformatf("frame data %0d", idx), 32'(char_data), 32'(idx % 256));
        end
        idx++;
        last_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (idx >= NUM_CHARS && cyc > last_cyc && mem_en) quiet = 0;
      @(negedge clk);
      cyc++;
    end
    check("frame char count", 32'(idx), 32'(NUM_CHARS));
    check("frame_done count", 32'(fd_cnt), 32'd1);
    check("frame_done timing", 32'(fd_cyc), 32'(last_cyc + 1));
    check("scan idle after frame", 32'(quiet), 32'd1);

    // CPU vector table, scan inactive.
    for (int i = 0; i < 12; i++) cpu_txn($sformatf("vec%0d", i), vecs[i]);
    @(negedge clk);
    check("rdata hold after ack", cpu_rdata, 32'd0);

    // CPU request against a running scan.
    char_ready = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (cpu_ack) got = 1;
    end
    check("starve ack within 8", 32'(got && lat <= 8), 32'd1);
    check("starve rdata", cpu_rdata, 32'h05);
    cpu_req = 1'b0;

    // Backpressure: restart with char_ready low, first char must be (0,0).
    char_ready = 1'b0;
    pulse_start();
    wait_valid("bp");
    check("bp row", 32'(char_row), 32'd0);
    check("bp col", 32'(char_col), 32'd0);
    check("bp data", 32'(char_data), 32'h5A);
    d0 = char_data; r0 = char_row; c0 = char_col;
    stable = 1; quiet = 1;
    repeat (10) begin
      @(negedge clk);
      if (!char_valid || char_data !== d0 || char_row !== r0 || char_col !== c0) stable = 0;
      if (mem_en) quiet = 0;
    end
    check("bp char stable", 32'(stable), 32'd1);
    check("bp no fetch", 32'(quiet), 32'd1);

    // Let a few characters go, then restart while one is held.
    char_ready = 1'b1;
    repeat (9) @(negedge clk);
    char_ready = 1'b0;
    wait_valid("mid");
    check("mid not origin", 32'((char_row != 0) || (char_col != 0)), 32'd1);
    pulse_start();
    check("restart clears valid", 32'(char_valid), 32'd0);
    wait_valid("restart");
    check("restart row", 32'(char_row), 32'd0);
    check("restart col", 32'(char_col), 32'd0);
    check("restart data", 32'(char_data), 32'h5A);

    // Restart landing on an in-flight fetch: its data must be discarded.
    char_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_en) got = 1;
    end
    check("inflight fetch seen", 32'(got), 32'd1);
    scan_start = 1'b1;
    char_ready = 1'b0;
    @(negedge clk);
    scan_start = 1'b0;
    wait_valid("discard");
    check("discard row", 32'(char_row), 32'd0);
    check("discard col", 32'(char_col), 32'd0);
    check("discard data", 32'(char_data), 32'h5A);

    // Reset in CPU_ISSUE: no ack, outputs clear at once, then normal use.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
    @(negedge clk);
    check("rst2 in issue", 32'(mem_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rst2 cpu_ack",    32'(cpu_ack),    32'd0);
    check("rst2 cpu_rdata",  cpu_rdata,       32'd0);
    check("rst2 char_valid", 32'(char_valid), 32'd0);
    check("rst2 char_data",  32'(char_data),  32'd0);
    check("rst2 char_pos",   32'({char_row, char_col}), 32'd0);
    check("rst2 mem_en",     32'(mem_en),     32'd0);
    check("rst2 mem_we",     32'(mem_we),     32'd0);
    check("rst2 frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    quiet = 1;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack || char_valid || mem_en) quiet = 0;
    end
    check("rst2 quiet after", 32'(quiet), 32'd1);
    cpu_txn("post reset", '{1'b0, 32'h8, 32'h0, 1'b1, 32'd2, 32'h41});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
